// File: rtl/audio_stereo_gain_if.sv
// Stereo sample stream bundle: left/right valid/ready inputs from the ADC side
// and left/right valid/ready outputs toward the DAC side.
interface audio_stereo_gain_if #(
  parameter int unsigned DATA_W = 24
);

  logic [DATA_W-1:0] in_left_data;
  logic              in_left_valid;
  logic              in_left_ready;
  logic [DATA_W-1:0] in_right_data;
  logic              in_right_valid;
  logic              in_right_ready;

  logic [DATA_W-1:0] out_left_data;
  logic              out_left_valid;
  logic              out_left_ready;
  logic [DATA_W-1:0] out_right_data;
  logic              out_right_valid;
  logic              out_right_ready;

  // Codec side: sources input samples, sinks processed samples
  modport master (
    output in_left_data, in_left_valid, input in_left_ready,
    output in_right_data, in_right_valid, input in_right_ready,
    input out_left_data, out_left_valid, output out_left_ready,
    input out_right_data, out_right_valid, output out_right_ready
  );

  // Gain stage side
  modport slave (
    input in_left_data, in_left_valid, output in_left_ready,
    input in_right_data, in_right_valid, output in_right_ready,
    output out_left_data, out_left_valid, input out_left_ready,
    output out_right_data, out_right_valid, input out_right_ready
  );

endinterface

// File: rtl/audio_stereo_gain.sv
// Stereo gain/mute stage: pairs left/right samples into a frame, applies
// per-channel saturating fixed-point gain from one shared snapshot, then drains.
module audio_stereo_gain #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned FRAC_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GAIN_W-1:0] gain_left,
  input  logic [GAIN_W-1:0] gain_right,
  input  logic              mute,
  input  logic              clear_clip,
  audio_stereo_gain_if.slave aud,
  output logic              clip_left,
  output logic              clip_right
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;

  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(GAIN_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {{(GAIN_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic [DATA_W-1:0]        OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0]        OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  // Returns {clipped, result}: signed sample times unsigned gain, floor-shifted, saturated
  function automatic logic [DATA_W:0] apply_gain(input logic [DATA_W-1:0] smp,
                                                 input logic [GAIN_W-1:0] gain);
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shf;
    prod = PROD_W'($signed(smp)) * PROD_W'($signed({1'b0, gain}));
    shf  = prod >>> FRAC_BITS;
    if (shf > SAT_MAX) begin
      return {1'b1, OUT_MAX};
    end else if (shf < SAT_MIN) begin
      return {1'b1, OUT_MIN};
    end
    return {1'b0, shf[DATA_W-1:0]};
  endfunction

  state_e            state_q, state_d;
  logic              l_cap_q, l_cap_d;
  logic              r_cap_q, r_cap_d;
  logic [DATA_W-1:0] l_smp_q, l_smp_d;
  logic [DATA_W-1:0] r_smp_q, r_smp_d;
  logic              in_l_rdy_q, in_l_rdy_d;
  logic              in_r_rdy_q, in_r_rdy_d;
  logic [DATA_W-1:0] out_l_data_q, out_l_data_d;
  logic [DATA_W-1:0] out_r_data_q, out_r_data_d;
  logic              out_l_vld_q, out_l_vld_d;
  logic              out_r_vld_q, out_r_vld_d;
  logic              clip_l_q, clip_l_d;
  logic              clip_r_q, clip_r_d;

  logic              l_hs;
  logic              r_hs;
  logic [DATA_W:0]   l_res;
  logic [DATA_W:0]   r_res;

  assign l_hs  = aud.in_left_valid & in_l_rdy_q;
  assign r_hs  = aud.in_right_valid & in_r_rdy_q;
  assign l_res = apply_gain(l_smp_q, gain_left);
  assign r_res = apply_gain(r_smp_q, gain_right);

  // Next-state and datapath decode
  always_comb begin
    state_d      = state_q;
    l_cap_d      = l_cap_q;
    r_cap_d      = r_cap_q;
    l_smp_d      = l_smp_q;
    r_smp_d      = r_smp_q;
    out_l_data_d = out_l_data_q;
    out_r_data_d = out_r_data_q;
    out_l_vld_d  = out_l_vld_q;
    out_r_vld_d  = out_r_vld_q;
    clip_l_d     = clip_l_q;
    clip_r_d     = clip_r_q;

    if (clear_clip) begin
      clip_l_d = 1'b0;
      clip_r_d = 1'b0;
    end

    case (state_q)
      ST_COLLECT: begin
        if (l_hs) begin
          l_cap_d = 1'b1;
          l_smp_d = aud.in_left_data;
        end
        if (r_hs) begin
          r_cap_d = 1'b1;
          r_smp_d = aud.in_right_data;
        end
        if (l_cap_q && r_cap_q) begin
          state_d = ST_COMPUTE;
        end
      end

      ST_COMPUTE: begin
        l_cap_d     = 1'b0;
        r_cap_d     = 1'b0;
        out_l_vld_d = 1'b1;
        out_r_vld_d = 1'b1;
        if (mute) begin
          out_l_data_d = '0;
          out_r_data_d = '0;
        end else begin
          out_l_data_d = l_res[DATA_W-1:0];
          out_r_data_d = r_res[DATA_W-1:0];
          // Set beats a same-cycle clear
          if (l_res[DATA_W]) clip_l_d = 1'b1;
          if (r_res[DATA_W]) clip_r_d = 1'b1;
        end
        state_d = ST_OUTPUT;
      end

      ST_OUTPUT: begin
        if (out_l_vld_q && aud.out_left_ready) out_l_vld_d = 1'b0;
        if (out_r_vld_q && aud.out_right_ready) out_r_vld_d = 1'b0;
        if (!out_l_vld_d && !out_r_vld_d) begin
          state_d = ST_COLLECT;
        end
      end

      default: begin
        state_d = ST_COLLECT;
        l_cap_d = 1'b0;
        r_cap_d = 1'b0;
      end
    endcase

    // Readies are registered, so derive them from where the FSM is heading
    in_l_rdy_d = (state_d == ST_COLLECT) && !l_cap_d;
    in_r_rdy_d = (state_d == ST_COLLECT) && !r_cap_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_COLLECT;
      l_cap_q      <= 1'b0;
      r_cap_q      <= 1'b0;
      l_smp_q      <= '0;
      r_smp_q      <= '0;
      in_l_rdy_q   <= 1'b0;
      in_r_rdy_q   <= 1'b0;
      out_l_data_q <= '0;
      out_r_data_q <= '0;
      out_l_vld_q  <= 1'b0;
      out_r_vld_q  <= 1'b0;
      clip_l_q     <= 1'b0;
      clip_r_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      l_cap_q      <= l_cap_d;
      r_cap_q      <= r_cap_d;
      l_smp_q      <= l_smp_d;
      r_smp_q      <= r_smp_d;
      in_l_rdy_q   <= in_l_rdy_d;
      in_r_rdy_q   <= in_r_rdy_d;
      out_l_data_q <= out_l_data_d;
      out_r_data_q <= out_r_data_d;
      out_l_vld_q  <= out_l_vld_d;
      out_r_vld_q  <= out_r_vld_d;
      clip_l_q     <= clip_l_d;
      clip_r_q     <= clip_r_d;
    end
  end

  assign aud.in_left_ready   = in_l_rdy_q;
  assign aud.in_right_ready  = in_r_rdy_q;
  assign aud.out_left_data   = out_l_data_q;
  assign aud.out_right_data  = out_r_data_q;
  assign aud.out_left_valid  = out_l_vld_q;
  assign aud.out_right_valid = out_r_vld_q;
  assign clip_left           = clip_l_q;
  assign clip_right          = clip_r_q;

endmodule

// File: doc/audio_stereo_gain.md
Name: audio_stereo_gain

Overview:
- Stereo gain/mute stage between the audio codec IP's ADC output streams and its DAC input streams.
- Consumes left/right 24-bit valid/ready sample streams and pairs them into a stereo frame.
- Applies per-channel fixed-point gain with saturation and presents the frame on left/right output streams.
- Frame-coherent: both channels of a frame always use the same gain/mute snapshot.

Parameters:
DATA_W, 24, sample width, signed two's complement
GAIN_W, 8, unsigned gain width
FRAC_BITS, 4, fractional bits of gain (0x10 = unity at defaults)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-low reset
gain_left  in  GAIN_W  unsigned left gain, UQ(GAIN_W-FRAC_BITS).FRAC_BITS
gain_right  in  GAIN_W  unsigned right gain
mute  in  1  1 = output zero samples
clear_clip  in  1  clears sticky clip flags
in_left_data  in  DATA_W  left sample from ADC stream
in_left_valid  in  1  left sample valid
in_left_ready  out  1  left sample accepted when valid&ready
in_right_data  in  DATA_W  right sample
in_right_valid  in  1  right sample valid
in_right_ready  out  1  right ready
out_left_data  out  DATA_W  processed left sample to DAC stream
out_left_valid  out  1  left output valid
out_left_ready  in  1  DAC left ready
out_right_data  out  DATA_W  processed right sample
out_right_valid  out  1  right output valid
out_right_ready  in  1  DAC right ready
clip_left  out  1  sticky: a left sample saturated
clip_right  out  1  sticky: a right sample saturated

Behaviour:
- Reset (reset==0 at clk edge): state COLLECT, both capture flags cleared, all ready/valid outputs 0, out data 0, clip flags 0. Reset mid-frame discards any captured or pending samples; no partial frame emitted afterwards.
- State COLLECT:
  - in_left_ready = 1 while left not yet captured; same for right.
  - Each channel captured independently on its own valid&ready handshake; order and skew between channels are unconstrained.
  - After a channel is captured its ready is 0 until the next frame.
  - When both are captured (same cycle or different cycles), next state COMPUTE.
- State COMPUTE (exactly 1 cycle):
  - Both in readies 0.
  - gain_left, gain_right and mute are sampled this cycle.
  - Per channel: product = signed(sample) * unsigned(gain), full width DATA_W+GAIN_W+1.
  - Arithmetic shift right FRAC_BITS (truncate toward -inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; saturation sets that channel's clip flag.
  - mute=1 forces both results to 0 and sets no clip flags.
  - Results registered into out_*_data; both out valids set to 1; next state OUTPUT.
- State OUTPUT:
  - Each out valid stays 1, with data held stable, until its own valid&ready; then it drops to 0.
  - When both channels have completed their handshakes (same cycle or different cycles), next state COLLECT.
  - In readies are 0 throughout OUTPUT: no new frame is accepted until both outputs drain.
- Latency: out valids rise 2 cycles after the edge on which the later input handshake occurs. Throughput is at most one frame per 4 cycles, far above the audio sample rate.
- Clip flags: set only in COMPUTE; cleared by clear_clip. If set and clear occur in the same cycle, set wins.
- Gain 0 yields 0 output with no clip. Max gain with full-scale input saturates without wrap.

Test Plan:
- Unity gain 0x10/0x10: in L=0x123456, R=0xFEDCBA -> out L=0x123456, R=0xFEDCBA, out valids exactly 2 cycles after the second capture, clip flags 0.
- Positive saturation: L=0x400000, gain_left=0x20 -> out L=0x7FFFFF, clip_left=1, clip_right=0. Then clear_clip pulse -> clip_left=0.
- Negative saturation and truncation:
  - R=0xC00000, gain_right=0x30 -> out R=0x800000, clip_right=1.
  - R=0xFFFFFF, gain 0x08 -> out R=0xFFFFFF (rounds toward -inf).
- Skew and backpressure:
  - Left valid 5 cycles before right -> left ready drops after capture, frame pairs correctly.
  - Hold out_right_ready=0 for 10 cycles -> out_left completes, out_right data stable, in readies stay 0 until right accepted.
- Mute and reset:
  - mute=1 in COMPUTE -> both outputs 0x000000, no clip.
  - Assert reset while in OUTPUT -> next cycle all valids/readies/flags 0. Following frame processes normally with no stale data.
